// File: rtl/sky130_fd_io__lvclamp_pkg.sv
// Shared types and default timing for the low-voltage ESD clamp trigger controller.
package sky130_fd_io__lvclamp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DEB  = 2'd1,
    FIRE = 2'd2,
    COOL = 2'd3
  } state_t;

  localparam int DEB_CYC_DEF  = 2;
  localparam int HOLD_CYC_DEF = 64;
  localparam int COOL_CYC_DEF = 16;
  localparam int TMR_W_DEF    = 8;
  localparam int CNT_W_DEF    = 8;

endpackage

// File: rtl/sky130_fd_io__lvclamp_tmr.sv
// Loadable down-counter shared by the debounce, hold and cooldown phases.
module sky130_fd_io__lvclamp_tmr #(
  parameter int TMR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [TMR_W-1:0] cnt_q, cnt_d;

  // Load wins over decrement; decrement saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/sky130_fd_io__lvclamp_trig_ctl.sv
// Ramp-detect qualifier, clamp-on hold timer and cooldown lockout driving the clamp gate.
module sky130_fd_io__lvclamp_trig_ctl
  import sky130_fd_io__lvclamp_pkg::*;
#(
  parameter int DEB_CYC  = DEB_CYC_DEF,
  parameter int HOLD_CYC = HOLD_CYC_DEF,
  parameter int COOL_CYC = COOL_CYC_DEF,
  parameter int TMR_W    = TMR_W_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             ramp_det,
  input  logic             force_on,
  input  logic             cnt_clr,
  output logic             ogc_en,
  output logic             active,
  output logic             cooldown,
  output logic [CNT_W-1:0] event_cnt
);

  localparam int TMR_MAX = (1 << TMR_W) - 1;

  if ((DEB_CYC < 1) || (HOLD_CYC < 1) || (COOL_CYC < 0) || (CNT_W < 1) ||
      (DEB_CYC > TMR_MAX) || (HOLD_CYC > TMR_MAX) || (COOL_CYC > TMR_MAX)) begin : g_bad_params
    $error("sky130_fd_io__lvclamp_trig_ctl: illegal timing parameters");
  end

  // The IDLE sample is the first qualifying one, so DEB only needs DEB_CYC-1 more.
  localparam logic [TMR_W-1:0] DEB_LD  = TMR_W'((DEB_CYC > 1) ? DEB_CYC - 2 : 0);
  localparam logic [TMR_W-1:0] HOLD_LD = TMR_W'(HOLD_CYC - 1);
  localparam logic [TMR_W-1:0] COOL_LD = TMR_W'((COOL_CYC > 0) ? COOL_CYC - 1 : 0);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmrLoad, tmrDec, tmrZero, fireEntry;
  logic [TMR_W-1:0] tmrLoadVal;

  sky130_fd_io__lvclamp_tmr #(.TMR_W(TMR_W)) u_tmr (
    .clk      (clk),
    .rst      (rst),
    .load     (tmrLoad),
    .load_val (tmrLoadVal),
    .dec      (tmrDec),
    .zero     (tmrZero)
  );

  always_comb begin
    state_d    = state_q;
    tmrLoad    = 1'b0;
    tmrLoadVal = '0;
    tmrDec     = 1'b0;
    fireEntry  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ramp_det && en) begin
          if (DEB_CYC == 1) begin
            state_d    = FIRE;
            tmrLoad    = 1'b1;
            tmrLoadVal = HOLD_LD;
            fireEntry  = 1'b1;
          end else begin
            state_d    = DEB;
            tmrLoad    = 1'b1;
            tmrLoadVal = DEB_LD;
          end
        end
      end
      DEB: begin
        if (!ramp_det || !en) begin
          state_d = IDLE;
        end else if (tmrZero) begin
          state_d    = FIRE;
          tmrLoad    = 1'b1;
          tmrLoadVal = HOLD_LD;
          fireEntry  = 1'b1;
        end else begin
          tmrDec = 1'b1;
        end
      end
      // A started discharge always completes, so en is ignored here.
      FIRE: begin
        if (ramp_det) begin
          tmrLoad    = 1'b1;
          tmrLoadVal = HOLD_LD;
        end else if (tmrZero) begin
          if (COOL_CYC == 0) begin
            state_d = IDLE;
          end else begin
            state_d    = COOL;
            tmrLoad    = 1'b1;
            tmrLoadVal = COOL_LD;
          end
        end else begin
          tmrDec = 1'b1;
        end
      end
      COOL: begin
        if (!en || tmrZero) begin
          state_d = IDLE;
        end else begin
          tmrDec = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (fireEntry && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign active    = (state_q == FIRE);
  assign cooldown  = (state_q == COOL);
  assign ogc_en    = active | force_on;
  assign event_cnt = cnt_q;

endmodule

// File: tb/tb_sky130_fd_io__lvclamp_trig_ctl.sv
// Directed scoreboard bench: default-parameter DUT plus a CNT_W=2 copy on shared stimulus.
module tb_sky130_fd_io__lvclamp_trig_ctl;
  import sky130_fd_io__lvclamp_pkg::*;

  logic       clk, rst, en, ramp_det, force_on, cnt_clr;
  logic       ogc_en, active, cooldown;
  logic [7:0] event_cnt;
  logic       ogcB, activeB, cooldownB;
  logic [1:0] event_cntB;

  typedef struct {
    string      tag;
    logic       ogc;
    logic       act;
    logic       cool;
    logic [7:0] cnt;
    logic [1:0] cntB;
  } exp_t;

  exp_t sbQ[$];
  int   checks = 0;
  int   errors = 0;
  int   expCnt = 0;
  int   expCntB = 0;

  sky130_fd_io__lvclamp_trig_ctl dut (
    .clk(clk), .rst(rst), .en(en), .ramp_det(ramp_det), .force_on(force_on),
    .cnt_clr(cnt_clr), .ogc_en(ogc_en), .active(active), .cooldown(cooldown),
    .event_cnt(event_cnt)
  );

  sky130_fd_io__lvclamp_trig_ctl #(.CNT_W(2)) dutB (
    .clk(clk), .rst(rst), .en(en), .ramp_det(ramp_det), .force_on(force_on),
    .cnt_clr(cnt_clr), .ogc_en(ogcB), .active(activeB), .cooldown(cooldownB),
    .event_cnt(event_cntB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic pushExp(input state_t st, input string tag);
    exp_t e;
    e.tag  = tag;
    e.act  = (st == FIRE);
    e.cool = (st == COOL);
    e.ogc  = (st == FIRE) | force_on;
    e.cnt  = 8'(expCnt);
    e.cntB = 2'(expCntB);
    sbQ.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    checks++;
    assert (sbQ.size() > 0) else begin
      errors++;
      $error("[TB] FAIL scoreboard_empty observed=0 expected=1");
    end
    if (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      checks++;
      assert (ogc_en === e.ogc) else begin
        errors++;
        $error("[TB] FAIL %s.ogc_en observed=%0b expected=%0b", e.tag, ogc_en, e.ogc);
      end
      checks++;
      assert (active === e.act) else begin
        errors++;
        $error("[TB] FAIL %s.active observed=%0b expected=%0b", e.tag, active, e.act);
      end
      checks++;
      assert (cooldown === e.cool) else begin
        errors++;
        $error("[TB] FAIL %s.cooldown observed=%0b expected=%0b", e.tag, cooldown, e.cool);
      end
      checks++;
      assert (event_cnt === e.cnt) else begin
        errors++;
        $error("[TB] FAIL %s.event_cnt observed=%0d expected=%0d", e.tag, event_cnt, e.cnt);
      end
      checks++;
      assert (ogcB === e.ogc) else begin
        errors++;
        $error("[TB] FAIL %s.ogc_en_B observed=%0b expected=%0b", e.tag, ogcB, e.ogc);
      end
      checks++;
      assert (event_cntB === e.cntB) else begin
        errors++;
        $error("[TB] FAIL %s.event_cnt_B observed=%0d expected=%0d", e.tag, event_cntB, e.cntB);
      end
    end
  endtask

  // Drive ramp_det for one cycle and check the state expected after the next edge.
  task automatic applyStimulus(input logic r, input state_t st, input string tag);
    ramp_det = r;
    pushExp(st, tag);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic checkNow(input state_t st, input string tag);
    #1;
    pushExp(st, tag);
    checkOutput();
  endtask

  task automatic bumpCnt();
    if (expCnt < 255) expCnt++;
    if (expCntB < 3) expCntB++;
  endtask

  task automatic fireOnce(input string tag);
    applyStimulus(1'b1, DEB, {tag, "_deb"});
    bumpCnt();
    applyStimulus(1'b1, FIRE, {tag, "_entry"});
    repeat (63) applyStimulus(1'b0, FIRE, {tag, "_hold"});
    repeat (16) applyStimulus(1'b0, COOL, {tag, "_cool"});
    applyStimulus(1'b0, IDLE, {tag, "_idle"});
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; ramp_det = 1'b0; force_on = 1'b0; cnt_clr = 1'b0;
    checkNow(IDLE, "reset");
    #2 rst = 1'b0;

    applyStimulus(1'b0, IDLE, "idle_quiet");
    fireOnce("basic");

    applyStimulus(1'b1, DEB, "glitch_deb");
    applyStimulus(1'b0, IDLE, "glitch_drop");
    applyStimulus(1'b0, IDLE, "glitch_idle");

    // Retrigger sampled 41 edges into FIRE stretches the window to 105 cycles.
    applyStimulus(1'b1, DEB, "retrig_deb");
    bumpCnt();
    applyStimulus(1'b1, FIRE, "retrig_entry");
    repeat (40) applyStimulus(1'b0, FIRE, "retrig_pre");
    applyStimulus(1'b1, FIRE, "retrig_pulse");
    repeat (63) applyStimulus(1'b0, FIRE, "retrig_post");
    applyStimulus(1'b0, COOL, "retrig_cool");

    repeat (15) applyStimulus(1'b1, COOL, "lockout_cool");
    applyStimulus(1'b1, IDLE, "lockout_exit");
    applyStimulus(1'b1, DEB, "lockout_deb");
    bumpCnt();
    applyStimulus(1'b1, FIRE, "lockout_refire");
    repeat (5) applyStimulus(1'b0, FIRE, "lockout_hold");

    #2 rst = 1'b1;
    expCnt = 0; expCntB = 0;
    checkNow(IDLE, "async_rst");
    rst = 1'b0;

    applyStimulus(1'b1, DEB, "force_deb");
    bumpCnt();
    applyStimulus(1'b1, FIRE, "force_entry");
    applyStimulus(1'b0, FIRE, "force_hold");
    force_on = 1'b1;
    checkNow(FIRE, "force_fire");
    rst = 1'b1;
    expCnt = 0; expCntB = 0;
    checkNow(IDLE, "async_rst_force");
    rst = 1'b0;
    force_on = 1'b0;
    checkNow(IDLE, "force_release");
    force_on = 1'b1;
    applyStimulus(1'b0, IDLE, "force_idle");
    force_on = 1'b0;

    for (int i = 0; i < 5; i++) fireOnce("sat");

    applyStimulus(1'b1, DEB, "clr_deb");
    cnt_clr = 1'b1;
    expCnt = 0; expCntB = 0;
    applyStimulus(1'b1, FIRE, "clr_vs_inc");
    cnt_clr = 1'b0;

    en = 1'b0;
    repeat (63) applyStimulus(1'b0, FIRE, "en_off_fire");
    applyStimulus(1'b0, COOL, "en_off_cool");
    applyStimulus(1'b0, IDLE, "en_off_exit");
    applyStimulus(1'b1, IDLE, "en_off_idle");
    en = 1'b1;
    applyStimulus(1'b1, DEB, "en_drop_deb");
    en = 1'b0;
    applyStimulus(1'b1, IDLE, "en_drop_idle");
    en = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
